// File: rtl/mul_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_pkg
// Brief    : FSM state type and ALU op encodings shared by the ALU, ALU
//            control and the multi-cycle multiplier sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mul_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   localparam logic [2:0] ALUCTRL_ADD  = 3'b000;
   localparam logic [2:0] ALUCTRL_SUB  = 3'b001;
   localparam logic [2:0] ALUCTRL_AND  = 3'b010;
   localparam logic [2:0] ALUCTRL_XOR  = 3'b011;
   localparam logic [2:0] ALUCTRL_SLL  = 3'b100;
   localparam logic [2:0] ALUCTRL_MUL  = 3'b101;
   localparam logic [2:0] ALUCTRL_SRAI = 3'b110;
   localparam logic [2:0] ALUCTRL_ADDI = 3'b111;

endpackage
`default_nettype wire

// File: rtl/mul_shift_add_dp.sv
`default_nettype none
// ============================================================================
// Module   : mul_shift_add_dp
// Brief    : Shift-add multiplier datapath: multiplicand/multiplier/accumulator
//            registers plus a result register, driven by load/step strobes.
//            MUL_EARLY_TERM_EN adds a post-shift multiplier==0 flag.
// Revision : 1.0 - initial release
// ============================================================================
module mul_shift_add_dp
   import mul_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic            i_step,
   input  logic            i_capture,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
`ifdef MUL_EARLY_TERM_EN
   output logic            o_b_next_zero,
`endif
   output logic [XLEN-1:0] o_result
);

   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_acc;
   logic [XLEN-1:0] r_result;
   logic [XLEN-1:0] w_acc_next;

   // Product is taken modulo 2^XLEN, so the carry out is simply dropped.
   assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);

`ifdef MUL_EARLY_TERM_EN
   assign o_b_next_zero = (r_b[XLEN-1:1] == '0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
      end else if (i_load) begin
         r_a   <= i_op_a;
         r_b   <= i_op_b;
         r_acc <= '0;
      end else if (i_step) begin
         r_acc <= w_acc_next;
         r_a   <= r_a << 1;
         r_b   <= r_b >> 1;
      end
   end

   // Separate result register so the output holds across later loads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= '0;
      end else if (i_step && i_capture) begin
         r_result <= w_acc_next;
      end
   end

   assign o_result = r_result;

endmodule
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_sequencer
// Brief    : Multi-cycle shift-add MUL controller for the EX stage; owns the
//            FSM, iteration counter and pipeline stall. Build option
//            MUL_EARLY_TERM_EN exits BUSY once the remaining multiplier is 0.
// Revision : 1.0 - initial release
// ============================================================================
module mul_sequencer
   import mul_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int              c_cnt_w = $clog2(XLEN) + 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(XLEN - 1);

   mul_state_t         r_state;
   mul_state_t         w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt;
   logic               w_load;
   logic               w_step;
   logic               w_capture;
   logic               w_stall;
   logic               w_last;
`ifdef MUL_EARLY_TERM_EN
   logic               w_b_next_zero;
`endif

`ifdef MUL_EARLY_TERM_EN
   assign w_last = (r_cnt == c_last) || w_b_next_zero;
`else
   assign w_last = (r_cnt == c_last);
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (w_load) begin
         r_cnt <= '0;
      end else if (w_step) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Flush wins in every state; DONE ignores start_i since the same MUL is still in EX.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_capture   = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_i && !flush_i) begin
               w_load      = 1'b1;
               w_stall     = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (flush_i) begin
               w_state_nxt = IDLE;
            end else begin
               w_step  = 1'b1;
               w_stall = 1'b1;
               if (w_last) begin
                  w_capture   = 1'b1;
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign stall_o = w_stall && !rst_i;
   assign busy_o  = (r_state == BUSY);
   assign done_o  = (r_state == DONE) && !flush_i;

   mul_shift_add_dp #(
      .XLEN(XLEN)
   ) u_dp (
      .clk          (clk_i),
      .rst          (rst_i),
      .i_load       (w_load),
      .i_step       (w_step),
      .i_capture    (w_capture),
      .i_op_a       (op_a_i),
      .i_op_b       (op_b_i),
`ifdef MUL_EARLY_TERM_EN
      .o_b_next_zero(w_b_next_zero),
`endif
      .o_result     (result_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_sequencer
// Brief    : Directed self-checking bench for mul_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        flush_i;
   logic [31:0] op_a_i;
   logic [31:0] op_b_i;
   logic        stall_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   mul_sequencer #(.XLEN(32)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .start_i (start_i),
      .flush_i (flush_i),
      .op_a_i  (op_a_i),
      .op_b_i  (op_b_i),
      .stall_o (stall_o),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .result_o(result_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected BUSY cycle count for a given multiplier.
   function automatic int exp_busy(input logic [31:0] b);
      int n;
      n = 1;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
`ifdef MUL_EARLY_TERM_EN
      return n;
`else
      return (n > 0) ? 32 : 0;
`endif
   endfunction

   // Drives one MUL starting just after a rising edge; measures, does not check.
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit keep,
                         output int n_stall, output int n_busy, output int done_cyc,
                         output int done_abs, output logic [31:0] res);
      n_stall  = 0;
      n_busy   = 0;
      done_cyc = -1;
      done_abs = -1;
      res      = 'x;
      start_i  = 1'b1;
      op_a_i   = a;
      op_b_i   = b;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (stall_o) n_stall++;
         if (busy_o)  n_busy++;
         if (done_o) begin
            done_cyc = c;
            done_abs = cyc;
            res      = result_o;
         end
         @(posedge clk); #1;
         if (done_cyc >= 0) break;
      end
      if (!keep) start_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b1; flush_i = 1'b0; op_a_i = 32'd3; op_b_i = 32'd5;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({stall_o, busy_o, done_o} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl: stall/busy/done=%b required 000", {stall_o, busy_o, done_o});
      end
      n_tests++;
      if (result_o !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_result: got %h required 0", result_o);
      end
      start_i = 1'b0;
      rst_i   = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int ns, nb, dc, da; logic [31:0] r;
      do_mul(32'd3, 32'd5, 1'b0, ns, nb, dc, da, r);
      n_tests++;
      if (r !== 32'd15) begin
         n_fail++; $display("FAIL basic_result: got %h required %h", r, 32'd15);
      end
      n_tests++;
      if (ns != exp_busy(32'd5) + 1) begin
         n_fail++; $display("FAIL basic_stall: got %0d required %0d", ns, exp_busy(32'd5) + 1);
      end
      n_tests++;
      if (dc != exp_busy(32'd5) + 1) begin
         n_fail++; $display("FAIL basic_done_cycle: got %0d required %0d", dc, exp_busy(32'd5) + 1);
      end
      @(negedge clk);
      n_tests++;
      if (done_o !== 1'b0 || stall_o !== 1'b0) begin
         n_fail++; $display("FAIL basic_pulse: done=%b stall=%b required 0 0", done_o, stall_o);
      end
      n_tests++;
      if (result_o !== 32'd15) begin
         n_fail++; $display("FAIL basic_hold: got %h required %h", result_o, 32'd15);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      int ns, nb, dc, da; logic [31:0] r;
      do_mul(32'hFFFF_FFFF, 32'd2, 1'b0, ns, nb, dc, da, r);
      n_tests++;
      if (r !== 32'hFFFF_FFFE) begin
         n_fail++; $display("FAIL wrap_result: got %h required %h", r, 32'hFFFF_FFFE);
      end
      n_tests++;
      if (nb != exp_busy(32'd2)) begin
         n_fail++; $display("FAIL wrap_busy: got %0d required %0d", nb, exp_busy(32'd2));
      end
   endtask

   task automatic test_back_to_back();
      int ns, nb, dc, da1, da2; logic [31:0] r1, r2;
      do_mul(32'd6, 32'd7, 1'b1, ns, nb, dc, da1, r1);
      do_mul(32'd9, 32'd9, 1'b0, ns, nb, dc, da2, r2);
      n_tests++;
      if (r1 !== 32'd42) begin
         n_fail++; $display("FAIL b2b_first: got %h required %h", r1, 32'd42);
      end
      n_tests++;
      if (r2 !== 32'd81) begin
         n_fail++; $display("FAIL b2b_second: got %h required %h", r2, 32'd81);
      end
      n_tests++;
      if (da2 - da1 != exp_busy(32'd9) + 2) begin
         n_fail++; $display("FAIL b2b_spacing: got %0d required %0d", da2 - da1, exp_busy(32'd9) + 2);
      end
   endtask

   task automatic test_flush();
      int ns, nb, dc, da; int ndone; logic [31:0] r;
      start_i = 1'b1; op_a_i = 32'd1; op_b_i = 32'hFFFF_FFFF;
      repeat (10) begin @(posedge clk); #1; end
      flush_i = 1'b1;
      @(negedge clk);
      n_tests++;
      if (stall_o !== 1'b0 || busy_o !== 1'b1) begin
         n_fail++; $display("FAIL flush_cycle: stall=%b busy=%b required 0 1", stall_o, busy_o);
      end
      @(posedge clk); #1;
      flush_i = 1'b0; start_i = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
         n_fail++; $display("FAIL flush_idle: busy=%b stall=%b required 0 0", busy_o, stall_o);
      end
      ndone = 0;
      repeat (40) begin @(negedge clk); if (done_o) ndone++; end
      n_tests++;
      if (ndone != 0) begin
         n_fail++; $display("FAIL flush_no_done: got %0d pulses required 0", ndone);
      end
      @(posedge clk); #1;
      do_mul(32'd2, 32'd2, 1'b0, ns, nb, dc, da, r);
      n_tests++;
      if (r !== 32'd4) begin
         n_fail++; $display("FAIL flush_next: got %h required %h", r, 32'd4);
      end
   endtask

   task automatic test_async_reset();
      int ns, nb, dc, da; logic [31:0] r;
      start_i = 1'b1; op_a_i = 32'd12345; op_b_i = 32'hF000_0000;
      repeat (6) begin @(posedge clk); #1; end
      #2 rst_i = 1'b1;
      #1;
      n_tests++;
      if ({stall_o, busy_o, done_o} !== 3'b000 || result_o !== 32'd0) begin
         n_fail++;
         $display("FAIL async_reset: stall/busy/done=%b result=%h required 000 0",
                  {stall_o, busy_o, done_o}, result_o);
      end
      start_i = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_i = 1'b0;
      @(posedge clk); #1;
      do_mul(32'd4, 32'd4, 1'b0, ns, nb, dc, da, r);
      n_tests++;
      if (r !== 32'd16) begin
         n_fail++; $display("FAIL reset_next: got %h required %h", r, 32'd16);
      end
   endtask

   task automatic test_early_term();
      int ns, nb, dc, da; logic [31:0] r;
      int e73, e50;
`ifdef MUL_EARLY_TERM_EN
      e73 = 2; e50 = 1;
`else
      e73 = 32; e50 = 32;
`endif
      do_mul(32'd7, 32'd3, 1'b0, ns, nb, dc, da, r);
      n_tests++;
      if (r !== 32'd21 || nb != e73) begin
         n_fail++; $display("FAIL early_7x3: result=%h busy=%0d required %h %0d", r, nb, 32'd21, e73);
      end
      do_mul(32'd5, 32'd0, 1'b0, ns, nb, dc, da, r);
      n_tests++;
      if (r !== 32'd0 || nb != e50) begin
         n_fail++; $display("FAIL early_5x0: result=%h busy=%0d required %h %0d", r, nb, 32'd0, e50);
      end
      n_tests++;
      if (dc != e50 + 1) begin
         n_fail++; $display("FAIL early_5x0_latency: got %0d required %0d", dc, e50 + 1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_early_term();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
